seven_seg_scan: RTL and testbench

//  Display stage directly downstream of the 4-bit character generator.
//  - Sends the generator a periodic scroll_tick and shifts each returned char into a 4-digit scrolling buffer.
//  - Time-multiplexes the buffer onto the board's 4-digit common-anode 7-segment display, with an all-off dead time between digits.

---
 rtl/seven_seg_pkg.sv | 36 +++
 rtl/seven_seg_decode.sv | 11 +
 rtl/seven_seg_scan.sv | 111 +++++++++++
 tb/tb_seven_seg_scan.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, scan-state encoding and hex-to-segment decode for the display blocks.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low segments, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex-to-7-segment decoder, reusable by any display block.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg_c
);

    assign seg_c = seg_decode(val);

endmodule

// File: rtl/seven_seg_scan.sv
// Scrolling 4-digit buffer multiplexed onto a common-anode 7-segment display
// with a blank dead time at the start of every digit slot.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES  = 500,
    parameter int unsigned SCROLL_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] char,
    input  logic       char_valid,
    input  logic       hold,
    output logic       scroll_tick,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned SLOT_W   = $clog2(DIGIT_CYCLES);
    localparam int unsigned SCROLL_W = $clog2(SCROLL_CYCLES);

    localparam logic [SLOT_W-1:0]   SLOT_LAST   = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]   SHOW_AT     = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_CYCLES - 1);

    logic [3:0][3:0]    char_buf;
    logic [3:0]         vmask;
    logic [1:0]         idx_q, idx_d;
    logic [SLOT_W-1:0]  slot_q;
    logic [SCROLL_W-1:0] scroll_q;
    scan_state_t        state_q, state_d;
    logic [3:0]         an_d;
    logic [6:0]         seg_d;
    logic [6:0]         dig_seg;

    seven_seg_decode u_decode (
        .val   (char_buf[idx_q]),
        .seg_c (dig_seg)
    );

    assign dp = 1'b1;

    // Character buffer: newest char enters digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            char_buf <= '0;
            vmask    <= '0;
        end else if (char_valid) begin
            char_buf <= {char_buf[2:0], char};
            vmask    <= {vmask[2:0], 1'b1};
        end
    end

    // Scan state, slot counter and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK;
            slot_q  <= '0;
            idx_q   <= '0;
            an      <= AN_OFF;
            seg     <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            slot_q  <= (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            idx_q   <= idx_d;
            an      <= an_d;
            seg     <= seg_d;
        end
    end

    // Digit value is sampled once at SHOW entry and held for the rest of the slot.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        an_d    = an;
        seg_d   = seg;
        case (state_q)
            BLANK: begin
                if (slot_q == SHOW_AT) begin
                    state_d = SHOW;
                    an_d    = ~(4'b0001 << idx_q);
                    seg_d   = vmask[idx_q] ? dig_seg : SEG_BLANK;
                end
            end
            SHOW: begin
                if (slot_q == SLOT_LAST) begin
                    state_d = BLANK;
                    idx_d   = idx_q + 2'd1;
                    an_d    = AN_OFF;
                    seg_d   = SEG_BLANK;
                end
            end
        endcase
    end

    // Scroll request timer; hold freezes the count in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_q    <= '0;
            scroll_tick <= 1'b0;
        end else begin
            scroll_tick <= !hold && (scroll_q == SCROLL_LAST);
            if (!hold) begin
                scroll_q <= (scroll_q == SCROLL_LAST) ? '0 : scroll_q + SCROLL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with short slot and scroll periods.
module tb_seven_seg_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] char = 4'h0;
    logic       char_valid = 1'b0;
    logic       hold = 1'b0;
    logic       scroll_tick;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    seven_seg_scan #(
        .DIGIT_CYCLES  (8),
        .BLANK_CYCLES  (2),
        .SCROLL_CYCLES (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .char_valid  (char_valid),
        .hold        (hold),
        .scroll_tick (scroll_tick),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic load(input logic [3:0] c);
        char       = c;
        char_valid = 1'b1;
        step();
        char_valid = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] e);
        int i;
        i = 0;
        while (an !== e && i < 64) begin
            step();
            i++;
        end
        check("wait_an", 16'(an), 16'(e));
    endtask

    task automatic show_is(input logic [3:0] e_an, input logic [6:0] e_seg, input string tag);
        wait_an(e_an);
        check(tag, 16'(seg), 16'(e_seg));
    endtask

    // Anode pattern of an idle display, cycle c counted from reset release.
    function automatic logic [3:0] idle_an(input int c);
        logic [3:0] m;
        if ((c % 8) < 2) return 4'hF;
        m = 4'b0001 << ((c / 8) % 4);
        return ~m;
    endfunction

    initial begin
        do_reset();
        check("rst_an",   16'(an),          16'h000F);
        check("rst_seg",  16'(seg),         16'h007F);
        check("rst_dp",   16'(dp),          16'h0001);
        check("rst_tick", 16'(scroll_tick), 16'h0000);

        // Idle scan: blank 2, show 6, digits rotate, all dark.
        for (int c = 0; c < 36; c++) begin
            check("idle_an",  16'(an),  16'(idle_an(cyc)));
            check("idle_seg", 16'(seg), 16'h007F);
            step();
        end

        // Four loads fill the buffer.
        load(4'h1); load(4'h2); load(4'h3); load(4'h4);
        repeat (32) step();
        show_is(4'hE, 7'h19, "fill_d0");
        show_is(4'hD, 7'h30, "fill_d1");
        show_is(4'hB, 7'h24, "fill_d2");
        show_is(4'h7, 7'h79, "fill_d3");

        // Fifth load pushes out the oldest char.
        load(4'hA);
        repeat (32) step();
        show_is(4'hE, 7'h08, "shift_d0");
        show_is(4'hD, 7'h19, "shift_d1");
        show_is(4'hB, 7'h30, "shift_d2");
        show_is(4'h7, 7'h24, "shift_d3");

        // Load during digit0 SHOW: held value until slot ends.
        show_is(4'hE, 7'h08, "mid_d0");
        load(4'hB);
        check("mid_hold_an",  16'(an),  16'h000E);
        check("mid_hold_seg", 16'(seg), 16'h0008);
        show_is(4'hD, 7'h08, "mid_d1");
        show_is(4'hB, 7'h19, "mid_d2");
        show_is(4'h7, 7'h30, "mid_d3");

        // Load on the SHOW-entry edge: pre-load value shown.
        wait_an(4'hF);
        step();
        load(4'hC);
        check("edge_an",  16'(an),  16'h000E);
        check("edge_seg", 16'(seg), 16'h0003);
        show_is(4'hD, 7'h03, "edge_d1");
        show_is(4'hE, 7'h46, "edge_d0_next");

        // Reset mid-SHOW with a full buffer, load attempted during reset.
        step();
        reset      = 1'b1;
        char       = 4'h5;
        char_valid = 1'b1;
        step();
        check("mid_rst_an",   16'(an),          16'h000F);
        check("mid_rst_seg",  16'(seg),         16'h007F);
        check("mid_rst_tick", 16'(scroll_tick), 16'h0000);
        reset      = 1'b0;
        char_valid = 1'b0;
        cyc        = 0;
        for (int c = 0; c < 40; c++) begin
            check("post_rst_an",  16'(an),  16'(idle_an(cyc)));
            check("post_rst_seg", 16'(seg), 16'h007F);
            step();
        end

        // Free-running scroll ticks.
        do_reset();
        for (int c = 0; c < 66; c++) begin
            check("tick", 16'(scroll_tick), 16'(cyc == 20 || cyc == 40 || cyc == 60));
            step();
        end

        // Hold over cycles 25..34 pushes the second tick out by ten.
        do_reset();
        for (int c = 0; c < 56; c++) begin
            hold = (cyc >= 25 && cyc <= 34);
            check("tick_hold", 16'(scroll_tick), 16'(cyc == 20 || cyc == 50));
            step();
        end
        hold = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
